sram_arbiter: RTL and testbench

Two-port arbiter sitting directly upstream of the external SRAM controller. It accepts level-held requests from an instruction-fetch port (read-only) and a data port (read/write), chooses one, and issues it to the controller as a single-cycle strobe. It then waits for the controller's one-cycle ack and returns the read data and an ack pulse to the winning port. A watchdog halts the arbiter with a sticky error if the controller never acks.

---
 rtl/sram_arbiter.sv | 138 +++++++++++++
 tb/tb_sram_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of the external SRAM controller.
// Issues one single-cycle strobe per transaction, waits for the controller ack, and halts on a watchdog timeout.
module sram_arbiter #(
    parameter int unsigned PRIO_RR = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stb,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_dtr,
    input  logic        d_stb,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_dtw,
    output logic        d_ack,
    output logic [31:0] d_dtr,
    output logic        m_stb,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_dtw,
    input  logic        m_ack,
    input  logic [31:0] m_dtr,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;
    typedef enum logic [1:0] {CD_NONE, CD_I, CD_D} cool_t;

    localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state, state_n;
    cool_t           cooldown;
    logic            last_grant;   // 1 = data port
    logic            winner;       // 1 = data port
    logic [WD_W-1:0] wd_cnt;
    logic            i_elig, d_elig;
    logic            grant, grant_d, wd_hit;

    // NOTE: every combinational output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        grant_d = 1'b0;
        wd_hit  = 1'b0;
        i_elig  = i_stb && (cooldown != CD_I);
        d_elig  = d_stb && (cooldown != CD_D);
        case (state)
            IDLE: begin
                if (i_elig || d_elig) begin
                    grant = 1'b1;
                    if (i_elig && d_elig)
                        grant_d = (PRIO_RR != 0) ? ~last_grant : 1'b1;
                    else
                        grant_d = d_elig;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (m_ack) begin
                    state_n = RESP;
                end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
                    wd_hit  = 1'b1;
                    state_n = ERR;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = ERR;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cooldown   <= CD_NONE;
            last_grant <= 1'b0;
            winner     <= 1'b0;
            wd_cnt     <= '0;
            m_stb      <= 1'b0;
            m_rw       <= 1'b0;
            m_addr     <= '0;
            m_dtw      <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_dtr      <= '0;
            d_dtr      <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_n;
            m_stb <= 1'b0;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        winner     <= grant_d;
                        last_grant <= grant_d;
                        m_stb      <= 1'b1;
                        m_addr     <= grant_d ? d_addr : i_addr;
                        m_rw       <= grant_d & d_rw;
                        m_dtw      <= grant_d ? d_dtw : '0;
                        wd_cnt     <= '0;
                        busy       <= 1'b1;
                    end else begin
                        // Any grant here necessarily goes to the non-cooldown port.
                        cooldown <= CD_NONE;
                    end
                end
                WAIT: begin
                    if (m_ack) begin
                        if (winner) begin
                            d_dtr <= m_dtr;
                            d_ack <= 1'b1;
                            cooldown <= CD_D;
                        end else begin
                            i_dtr <= m_dtr;
                            i_ack <= 1'b1;
                            cooldown <= CD_I;
                        end
                    end else if (wd_hit) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end else if (TIMEOUT != 0) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP:    busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed port traffic, a latency-programmable controller model,
// and monitors that check every strobe and every ack against a queue of expected transactions.
module tb_sram_arbiter;

    typedef struct {
        bit          is_d;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] dtw;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_stb, i_ack, d_stb, d_rw, d_ack, m_stb, m_rw, m_ack, busy, err;
    logic [31:0] i_addr, i_dtr, d_addr, d_dtw, d_dtr, m_addr, m_dtw, m_dtr;

    logic        b_i_stb, b_i_ack, b_d_stb, b_d_rw, b_d_ack, b_m_stb, b_m_rw, b_m_ack, b_busy, b_err;
    logic [31:0] b_i_addr, b_i_dtr, b_d_addr, b_d_dtw, b_d_dtr, b_m_addr, b_m_dtw, b_m_dtr;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t b_exp_q[$];
    exp_t iq[$];
    exp_t dq[$];

    int   stb_count = 0, ack_count = 0, mack_count = 0;
    bit   ctrl_en = 1'b1;
    int   ctrl_delay = 3;
    int   inj_req = 0, inj_done = 0;
    bit   c_pend = 1'b0;
    int   c_cnt = 0;
    logic [31:0] c_addr;
    logic prev_stb = 1'b0, prev_iack = 1'b0, prev_dack = 1'b0;
    exp_t mon_e, b_mon_e;

    always #5 clk = ~clk;

    sram_arbiter #(.PRIO_RR(1), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_stb(i_stb), .i_addr(i_addr), .i_ack(i_ack), .i_dtr(i_dtr),
        .d_stb(d_stb), .d_rw(d_rw), .d_addr(d_addr), .d_dtw(d_dtw), .d_ack(d_ack), .d_dtr(d_dtr),
        .m_stb(m_stb), .m_rw(m_rw), .m_addr(m_addr), .m_dtw(m_dtw), .m_ack(m_ack), .m_dtr(m_dtr),
        .busy(busy), .err(err)
    );

    sram_arbiter #(.PRIO_RR(0), .TIMEOUT(0)) dut_fixed (
        .clk(clk), .reset(reset),
        .i_stb(b_i_stb), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_dtr(b_i_dtr),
        .d_stb(b_d_stb), .d_rw(b_d_rw), .d_addr(b_d_addr), .d_dtw(b_d_dtw), .d_ack(b_d_ack), .d_dtr(b_d_dtr),
        .m_stb(b_m_stb), .m_rw(b_m_rw), .m_addr(b_m_addr), .m_dtw(b_m_dtw), .m_ack(b_m_ack), .m_dtr(b_m_dtr),
        .busy(b_busy), .err(b_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic exp_t mk(input bit is_d, input bit rw, input logic [31:0] addr, input logic [31:0] dtw);
        exp_t e;
        e.is_d  = is_d;
        e.rw    = is_d & rw;
        e.addr  = addr;
        e.dtw   = is_d ? dtw : 32'h0;
        e.rdata = rd_model(addr);
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_m_stb"}, 32'(m_stb), 0);
        check({tag, "_m_rw"}, 32'(m_rw), 0);
        check({tag, "_m_addr"}, m_addr, 0);
        check({tag, "_m_dtw"}, m_dtw, 0);
        check({tag, "_i_ack"}, 32'(i_ack), 0);
        check({tag, "_d_ack"}, 32'(d_ack), 0);
        check({tag, "_i_dtr"}, i_dtr, 0);
        check({tag, "_d_dtr"}, d_dtr, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    // Requester model: serves its queue back to back, then holds the stale stb through the cooldown cycle.
    task automatic drive_port(input bit is_d);
        exp_t r;
        int   n;
        bit   more;
        more = is_d ? (dq.size() != 0) : (iq.size() != 0);
        while (more) begin
            if (is_d) r = dq.pop_front();
            else      r = iq.pop_front();
            if (is_d) begin
                d_addr = r.addr; d_rw = r.rw; d_dtw = r.dtw; d_stb = 1'b1;
            end else begin
                i_addr = r.addr; i_stb = 1'b1;
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(is_d ? d_ack : i_ack) && n < 200);
            check(is_d ? "d_ack_arrived" : "i_ack_arrived", 32'(is_d ? d_ack : i_ack), 1);
            more = is_d ? (dq.size() != 0) : (iq.size() != 0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        if (is_d) d_stb = 1'b0;
        else      i_stb = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Controller model for the round-robin instance.
    initial begin
        m_ack = 1'b0;
        m_dtr = '0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (inj_req != inj_done) begin
                inj_done++;
                m_ack = 1'b1;
                m_dtr = 32'hBAD0_0BAD;
            end else if (c_pend) begin
                if (c_cnt == 0) begin
                    m_ack  = 1'b1;
                    m_dtr  = rd_model(c_addr);
                    c_pend = 1'b0;
                end else begin
                    c_cnt--;
                end
            end else if (m_stb && ctrl_en) begin
                c_pend = 1'b1;
                c_cnt  = ctrl_delay - 1;
                c_addr = m_addr;
            end
        end
    end

    // Controller model for the fixed-priority instance: acks one cycle after the strobe.
    initial begin
        b_m_ack = 1'b0;
        b_m_dtr = '0;
        forever begin
            @(negedge clk);
            b_m_ack = 1'b0;
            if (b_m_stb) begin
                b_m_ack = 1'b1;
                b_m_dtr = b_m_addr ^ 32'h5555_AAAA;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        if (m_ack) mack_count++;
    end

    // Monitor for the round-robin instance.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (m_stb) begin
                stb_count++;
                check("m_stb_one_cycle", 32'(prev_stb), 0);
                check("m_stb_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("m_rw", 32'(m_rw), 32'(exp_q[0].rw));
                    check("m_addr", m_addr, exp_q[0].addr);
                    check("m_dtw", m_dtw, exp_q[0].dtw);
                end
            end
            if (i_ack) check("i_ack_one_cycle", 32'(prev_iack), 0);
            if (d_ack) check("d_ack_one_cycle", 32'(prev_dack), 0);
            if (i_ack || d_ack) begin
                ack_count++;
                check("single_ack", 32'(i_ack && d_ack), 0);
                check("ack_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("ack_port", 32'(d_ack), 32'(mon_e.is_d));
                    check("dtr", mon_e.is_d ? d_dtr : i_dtr, mon_e.rdata);
                end
            end
        end
        prev_stb  = m_stb;
        prev_iack = i_ack;
        prev_dack = d_ack;
    end

    // Monitor for the fixed-priority instance.
    initial forever begin
        @(negedge clk);
        if (reset && (b_i_ack || b_d_ack)) begin
            check("fixed_ack_expected", 32'(b_exp_q.size() != 0), 1);
            if (b_exp_q.size() != 0) begin
                b_mon_e = b_exp_q.pop_front();
                check("fixed_ack_port", 32'(b_d_ack), 32'(b_mon_e.is_d));
                check("fixed_dtr", b_mon_e.is_d ? b_d_dtr : b_i_dtr, b_mon_e.addr ^ 32'h5555_AAAA);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual still running, required finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int   n, s0, a0, mc0;
        bit   got_i, got_d;
        exp_t e;

        reset = 1'b0;
        i_stb = 0; i_addr = 0; d_stb = 0; d_rw = 0; d_addr = 0; d_dtw = 0;
        b_i_stb = 0; b_i_addr = 0; b_d_stb = 0; b_d_rw = 0; b_d_addr = 0; b_d_dtw = 0;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Stray controller ack while idle must be ignored.
        a0 = ack_count; s0 = stb_count;
        inj_req++;
        repeat (4) @(negedge clk);
        check("idle_mack_no_ack", ack_count - a0, 0);
        check("idle_mack_no_stb", stb_count - s0, 0);

        // Single instruction read, controller acks after 5 cycles.
        ctrl_delay = 5;
        exp_q.push_back(mk(0, 0, 32'h0000_1000, 0));
        i_addr = 32'h0000_1000;
        i_stb  = 1'b1;
        n = 0;
        while (!m_stb && n < 100) begin @(negedge clk); n++; end
        check("t1_stb_seen", 32'(m_stb), 1);
        check("t1_busy_wait", 32'(busy), 1);
        n = 0;
        while (!i_ack && n < 100) begin @(negedge clk); n++; end
        check("t1_i_ack_seen", 32'(i_ack), 1);
        check("t1_busy_resp", 32'(busy), 1);
        @(negedge clk);
        check("t1_busy_idle", 32'(busy), 0);
        check("t1_i_dtr_held", i_dtr, 32'hDEAD_BEEF);
        @(posedge clk);
        #1 i_stb = 1'b0;
        repeat (3) @(negedge clk);

        // Data write; instruction data must stay untouched.
        ctrl_delay = 3;
        e = mk(1, 1, 32'h0000_0003, 32'h1122_3344);
        exp_q.push_back(e);
        dq.push_back(e);
        drive_port(1);
        repeat (3) @(negedge clk);
        check("t2_i_dtr_held", i_dtr, 32'hDEAD_BEEF);
        check("t2_d_dtr_held", d_dtr, 32'hC0DE_0003);

        // Both ports held continuously from reset: D, I, D, I.
        do_reset();
        ctrl_delay = 2;
        exp_q.push_back(mk(1, 1, 32'h0000_3000, 32'h0000_00A1));
        exp_q.push_back(mk(0, 0, 32'h0000_2000, 0));
        exp_q.push_back(mk(1, 0, 32'h0000_3008, 32'hFFFF_0000));
        exp_q.push_back(mk(0, 0, 32'h0000_2004, 0));
        dq.push_back(mk(1, 1, 32'h0000_3000, 32'h0000_00A1));
        dq.push_back(mk(1, 0, 32'h0000_3008, 32'hFFFF_0000));
        iq.push_back(mk(0, 0, 32'h0000_2000, 0));
        iq.push_back(mk(0, 0, 32'h0000_2004, 0));
        fork
            drive_port(0);
            drive_port(1);
        join
        repeat (4) @(negedge clk);
        check("rr_drained", exp_q.size(), 0);

        // After a lone D grant, a fresh tie goes to I under round-robin.
        ctrl_delay = 1;
        exp_q.push_back(mk(1, 0, 32'h0000_6000, 0));
        dq.push_back(mk(1, 0, 32'h0000_6000, 0));
        drive_port(1);
        repeat (3) @(negedge clk);
        exp_q.push_back(mk(0, 0, 32'h0000_6100, 0));
        exp_q.push_back(mk(1, 1, 32'h0000_6200, 32'h0000_0077));
        iq.push_back(mk(0, 0, 32'h0000_6100, 0));
        dq.push_back(mk(1, 1, 32'h0000_6200, 32'h0000_0077));
        fork
            drive_port(0);
            drive_port(1);
        join
        repeat (4) @(negedge clk);
        check("tie_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of WAIT, then a late controller ack.
        ctrl_delay = 6;
        exp_q.push_back(mk(0, 0, 32'h0000_4000, 0));
        i_addr = 32'h0000_4000;
        i_stb  = 1'b1;
        n = 0;
        while (!m_stb && n < 100) begin @(negedge clk); n++; end
        check("rst_stb_seen", 32'(m_stb), 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_all_zero("async_rst");
        exp_q.delete();
        i_stb = 1'b0;
        mc0 = mack_count; a0 = ack_count;
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("late_mack_arrived", mack_count - mc0, 1);
        check("late_mack_no_ack", ack_count - a0, 0);

        // Watchdog: controller never acks.
        ctrl_en = 1'b0;
        exp_q.push_back(mk(1, 1, 32'h0000_5000, 32'h0000_0055));
        d_addr = 32'h0000_5000; d_rw = 1'b1; d_dtw = 32'h0000_0055; d_stb = 1'b1;
        n = 0;
        while (!m_stb && n < 100) begin @(negedge clk); n++; end
        check("wd_stb_seen", 32'(m_stb), 1);
        repeat (7) @(negedge clk);
        check("wd_err_before", 32'(err), 0);
        check("wd_busy_before", 32'(busy), 1);
        @(negedge clk);
        check("wd_err_at_8", 32'(err), 1);
        check("wd_busy_at_8", 32'(busy), 0);
        exp_q.delete();
        i_addr = 32'h0000_7000;
        i_stb  = 1'b1;
        s0 = stb_count; a0 = ack_count;
        inj_req++;
        repeat (20) @(negedge clk);
        check("err_no_stb", stb_count - s0, 0);
        check("err_no_ack", ack_count - a0, 0);
        check("err_sticky", 32'(err), 1);
        i_stb = 1'b0;
        d_stb = 1'b0;
        reset = 1'b0;
        #1 check("err_cleared", 32'(err), 0);
        @(negedge clk);
        reset = 1'b1;
        ctrl_en = 1'b1;
        @(negedge clk);

        // Fixed priority: after a lone D grant, a fresh tie still goes to D.
        b_exp_q.push_back(mk(1, 0, 32'h0000_0010, 0));
        b_d_addr = 32'h0000_0010;
        b_d_stb  = 1'b1;
        n = 0;
        while (!b_d_ack && n < 100) begin @(negedge clk); n++; end
        check("fixed_first_ack", 32'(b_d_ack), 1);
        b_d_stb = 1'b0;
        repeat (3) @(negedge clk);
        b_exp_q.push_back(mk(1, 0, 32'h0000_0020, 0));
        b_exp_q.push_back(mk(0, 0, 32'h0000_0024, 0));
        b_d_addr = 32'h0000_0020;
        b_i_addr = 32'h0000_0024;
        b_d_stb  = 1'b1;
        b_i_stb  = 1'b1;
        got_i = 0; got_d = 0; n = 0;
        while (!(got_i && got_d) && n < 100) begin
            @(negedge clk);
            n++;
            if (b_d_ack) begin got_d = 1; b_d_stb = 1'b0; end
            if (b_i_ack) begin got_i = 1; b_i_stb = 1'b0; end
        end
        check("fixed_both_acked", 32'(got_i && got_d), 1);
        repeat (4) @(negedge clk);
        check("fixed_drained", b_exp_q.size(), 0);
        check("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
